// File: rtl/demux1_4_if.sv
// demux1_4_if -- bundle of the routed-input handshake and the four channel
// output handshakes of demux1_4.
//   in_data/in_sel/in_valid/in_ready : input word, destination channel, handshake
//   w/x/y/z, *_valid, *_ready        : per-channel head data and handshake
// Modports: master = traffic source/sink side (testbench or surrounding logic),
//           slave  = the demux itself.
interface demux1_4_if;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;

    logic [3:0] w;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       w_valid;
    logic       x_valid;
    logic       y_valid;
    logic       z_valid;
    logic       w_ready;
    logic       x_ready;
    logic       y_ready;
    logic       z_ready;

    modport master (
        output in_data, in_sel, in_valid,
        input  in_ready,
        input  w, x, y, z,
        input  w_valid, x_valid, y_valid, z_valid,
        output w_ready, x_ready, y_ready, z_ready
    );

    modport slave (
        input  in_data, in_sel, in_valid,
        output in_ready,
        output w, x, y, z,
        output w_valid, x_valid, y_valid, z_valid,
        input  w_ready, x_ready, y_ready, z_ready
    );
endinterface

// File: rtl/demux1_4.sv
// demux1_4 -- routes 4-bit words to one of four output channels, each of which
// buffers up to two words in its own FIFO.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset (clears counts and pointers)
//   bus : demux1_4_if.slave
//         in_data/in_sel/in_valid -> word, destination (0=w,1=x,2=y,3=z), valid
//         in_ready                <- selected channel is not full
//         w/x/y/z, *_valid        <- head of each channel FIFO (0 when empty)
//         *_ready                 -> consumer takes the head word
module demux1_4 (
    input  logic        clk,
    input  logic        rst,
    demux1_4_if.slave   bus
);

    localparam int unsigned NCH   = 4;
    localparam logic [1:0]  FULL  = 2'd2;

    logic [1:0] count_q  [NCH];
    logic [1:0] count_d  [NCH];
    logic       rd_ptr_q [NCH];
    logic       rd_ptr_d [NCH];
    logic       wr_ptr_q [NCH];
    logic       wr_ptr_d [NCH];
    logic [3:0] mem_q    [NCH][2];
    logic [3:0] mem_d    [NCH][2];

    logic [NCH-1:0] ch_ready;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [3:0]     head [NCH];
    logic           in_ready;
    logic           in_fire;

    assign ch_ready = {bus.z_ready, bus.y_ready, bus.x_ready, bus.w_ready};

    // Readiness looks only at the registered count of the selected channel,
    // so a pop in the same cycle cannot open a slot for the incoming word.
    assign in_ready = (count_q[bus.in_sel] != FULL);
    assign in_fire  = bus.in_valid && in_ready;

    always_comb begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            push[ch]     = in_fire && (bus.in_sel == 2'(ch));
            pop[ch]      = (count_q[ch] != 2'd0) && ch_ready[ch];

            count_d[ch]  = count_q[ch] + {1'b0, push[ch]} - {1'b0, pop[ch]};
            wr_ptr_d[ch] = wr_ptr_q[ch] ^ push[ch];
            rd_ptr_d[ch] = rd_ptr_q[ch] ^ pop[ch];

            mem_d[ch][0] = mem_q[ch][0];
            mem_d[ch][1] = mem_q[ch][1];
            if (push[ch]) begin
                mem_d[ch][wr_ptr_q[ch]] = bus.in_data;
            end

            head[ch] = (count_q[ch] != 2'd0) ? mem_q[ch][rd_ptr_q[ch]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (rst) begin
                count_q[ch]  <= '0;
                rd_ptr_q[ch] <= 1'b0;
                wr_ptr_q[ch] <= 1'b0;
            end else begin
                count_q[ch]  <= count_d[ch];
                rd_ptr_q[ch] <= rd_ptr_d[ch];
                wr_ptr_q[ch] <= wr_ptr_d[ch];
            end
        end
    end

    // Storage is not reset: every output is masked while its count is zero.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            mem_q[ch][0] <= mem_d[ch][0];
            mem_q[ch][1] <= mem_d[ch][1];
        end
    end

    assign bus.in_ready = in_ready;

    assign bus.w       = head[0];
    assign bus.x       = head[1];
    assign bus.y       = head[2];
    assign bus.z       = head[3];
    assign bus.w_valid = (count_q[0] != 2'd0);
    assign bus.x_valid = (count_q[1] != 2'd0);
    assign bus.y_valid = (count_q[2] != 2'd0);
    assign bus.z_valid = (count_q[3] != 2'd0);

endmodule

// File: doc/demux1_4.md
DEMUX1_4 -- requirements
Module: demux1_4

Interface
REQ-001 Parameters: none; the data width is fixed at 4 bits and the channel count is fixed at 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_data  input  4  data word to be routed.
REQ-005 in_sel  input  2  destination channel: 0->w, 1->x, 2->y, 3->z.
REQ-006 in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-007 in_ready  output  1  block accepts the input word this cycle.
REQ-008 w, x, y, z  output  4 each  head-of-buffer data for channels 0..3.
REQ-009 w_valid, x_valid, y_valid, z_valid  output  1 each  the matching channel output holds a valid word.
REQ-010 w_ready, x_ready, y_ready, z_ready  input  1 each  the downstream consumer of that channel takes the word.

Function
REQ-011 Each channel SHALL own an independent 2-entry FIFO, with its own 2-bit occupancy count (0..2) and a 1-bit read and write pointer.
REQ-012 An input transfer SHALL occur when in_valid=1 and in_ready=1 on a rising clk; in_data is written into the FIFO selected by in_sel.
REQ-013 in_ready SHALL be combinational and equal to (count[in_sel] != 2); a pop on the same cycle SHALL NOT raise in_ready.
REQ-014 in_ready SHALL NOT depend on in_valid; with in_valid=0 it still reflects the state of the selected channel.
REQ-015 A channel pop SHALL occur when <ch>_valid=1 and <ch>_ready=1 on a rising clk.
REQ-016 <ch>_valid SHALL equal (count[ch] != 0), driven from registered state only.
REQ-017 <ch> data SHALL equal the entry at that channel's read pointer when count != 0, and 4'b0000 when count = 0.
REQ-018 Latency: a word accepted at edge N SHALL be visible on its channel with valid=1 after edge N, i.e. in the next cycle (1 cycle).
REQ-019 Per-channel ordering SHALL be FIFO; words routed to different channels have no mutual ordering.
REQ-020 Simultaneous push and pop on the same channel with count=1 SHALL leave count=1, output the newly pushed word next cycle, and lose no data.
REQ-021 Simultaneous push and pop with count=0 is impossible because valid=0; only the push takes effect.
REQ-022 When count=2, a push is blocked via in_ready=0; a pop in the same cycle SHALL decrement count to 1.
REQ-023 Pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow below 0.
REQ-024 A <ch>_ready asserted while <ch>_valid=0 SHALL have no effect.
REQ-025 Non-selected channels SHALL be unaffected by the input transfer and keep draining independently.
REQ-026 in_sel and in_data SHALL be ignored when in_valid=0; no state changes.

Reset
REQ-027 While rst=1 at a rising edge, all counts and pointers SHALL become 0.
REQ-028 After reset, all <ch>_valid SHALL be 0 and w/x/y/z SHALL be 4'b0000.
REQ-029 After reset, in_ready SHALL be 1 for every in_sel value.
REQ-030 rst SHALL take priority over any simultaneous push or pop; buffered words are discarded mid-operation.
REQ-031 Buffer storage contents need not be cleared, because outputs are masked to 0 when count=0.

Verification
REQ-032 Reset then idle: all valids 0, all outputs 4'h0, in_ready=1 for in_sel=0..3.
REQ-033 Push 4'hA with sel=2, y_ready=0: next cycle y=4'hA and y_valid=1; w, x and z stay invalid.
REQ-034 Push 4'h1 then 4'h2 to sel=0 with w_ready=0: in_ready=0 for sel=0 and 1 for sel=1; raise w_ready to drain in order 1 then 2.
REQ-035 With x holding 4'h3 (count=1), push 4'h4 to sel=1 while x_ready=1: next cycle x=4'h4, x_valid=1, count=1.
REQ-036 Fill channel z with 4'h5 and 4'h6, then assert rst for one cycle with in_valid=1: z_valid=0, z=4'h0, in_ready=1.
REQ-037 Random traffic, 10k cycles, random sel, valid and readies: each channel's output stream matches a reference queue, with no loss or duplication.
